debug_run_ctrl: RTL and testbench

DEBUG_RUN_CTRL -- requirements
Module: debug_run_ctrl

---
 rtl/dbg_pkg.sv | 29 ++
 rtl/debug_run_ctrl_if.sv | 24 ++
 rtl/dbg_bp_match.sv | 26 ++
 rtl/debug_run_ctrl.sv | 175 +++++++++++++++++
 tb/tb_debug_run_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbg_pkg.sv
// Debug run-control shared types: FSM states, command opcodes,
// halt-cause codes and an index-width helper.
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_HALT    = 3'd2;
  localparam logic [2:0] OP_STEP    = 3'd3;
  localparam logic [2:0] OP_SET_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_BP  = 3'd5;
  localparam logic [2:0] OP_CLR_CNT = 3'd6;

  localparam logic [2:0] HC_RESET = 3'd0;
  localparam logic [2:0] HC_CMD   = 3'd1;
  localparam logic [2:0] HC_BP    = 3'd2;
  localparam logic [2:0] HC_STEP  = 3'd3;
  localparam logic [2:0] HC_EXT   = 3'd4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_run_ctrl_if.sv
// Debug command channel: valid/ready handshake carrying opcode,
// breakpoint index and data. master = debugger, slave = controller.
interface debug_run_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int NUM_BP = 4
) ();
  localparam int IDX_W = dbg_pkg::idx_w(NUM_BP);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [IDX_W-1:0] cmd_idx;
  logic [XLEN-1:0]  cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_idx, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/dbg_bp_match.sv
// PC breakpoint comparators with lowest-index priority encode.
// In: pc, addr/en per channel. Out: hit, idx of lowest match.
module dbg_bp_match #(
  parameter int XLEN   = 64,
  parameter int NUM_BP = 4,
  parameter int IDX_W  = 2
) (
  input  logic [XLEN-1:0]             pc,
  input  logic [NUM_BP-1:0][XLEN-1:0] addr,
  input  logic [NUM_BP-1:0]           en,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx
);

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (en[i] && (addr[i] == pc)) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/debug_run_ctrl.sv
// Run/halt/step controller for a single-cycle CPU with PC breakpoints.
// Ports: clk, rst_n, pc, halt_req, cmd (slave), cpu_en, halted,
// halt_cause, bp_idx, cycle_count.
module debug_run_ctrl
  import dbg_pkg::*;
#(
  parameter int  XLEN    = 64,
  parameter int  NUM_BP  = 4,
  parameter int  CYCLE_W = 32,
  localparam int IDX_W   = idx_w(NUM_BP)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [XLEN-1:0]     pc,
  input  logic                halt_req,
  debug_run_ctrl_if.slave     cmd,
  output logic                cpu_en,
  output logic                halted,
  output logic [2:0]          halt_cause,
  output logic [IDX_W-1:0]    bp_idx,
  output logic [CYCLE_W-1:0]  cycle_count
);

  state_e                     state_q, state_d;
  logic                       skip_q, skip_d;
  logic [CYCLE_W-1:0]         rem_q, rem_d;
  logic [CYCLE_W-1:0]         cyc_q, cyc_d;
  logic [2:0]                 cause_q, cause_d;
  logic [IDX_W-1:0]           bpi_q, bpi_d;
  logic [NUM_BP-1:0][XLEN-1:0] addr_q, addr_d;
  logic [NUM_BP-1:0]          en_q, en_d;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic               acc, bp_stop, idx_ok;
  logic               do_run, do_halt, do_step;
  logic               do_set, do_clr, do_clr_cnt;
  logic [CYCLE_W-1:0] step_ld;

  dbg_bp_match #(
    .XLEN   (XLEN),
    .NUM_BP (NUM_BP),
    .IDX_W  (IDX_W)
  ) u_match (
    .pc   (pc),
    .addr (addr_q),
    .en   (en_q),
    .hit  (hit),
    .idx  (hit_idx)
  );

  // Ready is forced low during reset, so it follows rst_n directly.
  assign cmd.cmd_ready = rst_n && (state_q != ST_STEP);
  assign acc     = cmd.cmd_valid && cmd.cmd_ready;
  assign idx_ok  = 32'(cmd.cmd_idx) < 32'(NUM_BP);
  assign step_ld = (cmd.cmd_data[CYCLE_W-1:0] == '0) ?
                   CYCLE_W'(1) : cmd.cmd_data[CYCLE_W-1:0];

  // The first RUN cycle after resume skips the breakpoint check.
  assign bp_stop = (state_q == ST_RUN) && hit && !skip_q;
  assign cpu_en  = ((state_q == ST_RUN) && !bp_stop) ||
                   (state_q == ST_STEP);

  assign halted      = (state_q == ST_HALT);
  assign halt_cause  = cause_q;
  assign bp_idx      = bpi_q;
  assign cycle_count = cyc_q;

  always_comb begin
    do_run     = 1'b0;
    do_halt    = 1'b0;
    do_step    = 1'b0;
    do_set     = 1'b0;
    do_clr     = 1'b0;
    do_clr_cnt = 1'b0;
    if (acc) begin
      case (cmd.cmd_op)
        OP_RUN:     do_run     = 1'b1;
        OP_HALT:    do_halt    = 1'b1;
        OP_STEP:    do_step    = 1'b1;
        OP_SET_BP:  do_set     = 1'b1;
        OP_CLR_BP:  do_clr     = 1'b1;
        OP_CLR_CNT: do_clr_cnt = 1'b1;
        OP_NOP:     ;
        default:    ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = 1'b0;
    rem_d   = rem_q;
    cause_d = cause_q;
    bpi_d   = bpi_q;
    unique case (state_q)
      ST_HALT: begin
        if (!halt_req) begin
          if (do_run) begin
            state_d = ST_RUN;
            skip_d  = 1'b1;
          end else if (do_step) begin
            state_d = ST_STEP;
            rem_d   = step_ld;
          end
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
          cause_d = HC_EXT;
        end else if (bp_stop) begin
          state_d = ST_HALT;
          cause_d = HC_BP;
          bpi_d   = hit_idx;
        end else if (do_halt) begin
          state_d = ST_HALT;
          cause_d = HC_CMD;
        end
      end
      ST_STEP: begin
        rem_d = rem_q - CYCLE_W'(1);
        if (halt_req) begin
          state_d = ST_HALT;
          cause_d = HC_EXT;
        end else if (rem_q == CYCLE_W'(1)) begin
          state_d = ST_HALT;
          cause_d = HC_STEP;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    en_d   = en_q;
    if (idx_ok && do_set) begin
      addr_d[cmd.cmd_idx] = cmd.cmd_data;
      en_d[cmd.cmd_idx]   = 1'b1;
    end
    if (idx_ok && do_clr) begin
      en_d[cmd.cmd_idx] = 1'b0;
    end
    cyc_d = cyc_q;
    if (do_clr_cnt) begin
      cyc_d = '0;
    end else if (cpu_en && !(&cyc_q)) begin
      cyc_d = cyc_q + CYCLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HALT;
      skip_q  <= 1'b0;
      rem_q   <= '0;
      cyc_q   <= '0;
      cause_q <= HC_RESET;
      bpi_q   <= '0;
      addr_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      rem_q   <= rem_d;
      cyc_q   <= cyc_d;
      cause_q <= cause_d;
      bpi_q   <= bpi_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
    end
  end

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Bench for debug_run_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural run-control model.
module tb_debug_run_ctrl;

  localparam int XLEN    = 64;
  localparam int NUM_BP  = 4;
  localparam int CYCLE_W = 4;
  localparam int IDX_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [XLEN-1:0]    pc = '0;
  logic               halt_req = 1'b0;
  logic               cpu_en, halted;
  logic [2:0]         halt_cause;
  logic [IDX_W-1:0]   bp_idx;
  logic [CYCLE_W-1:0] cycle_count;

  int errors = 0;
  int checks = 0;

  debug_run_ctrl_if #(.XLEN(XLEN), .NUM_BP(NUM_BP)) bus ();

  debug_run_ctrl #(
    .XLEN    (XLEN),
    .NUM_BP  (NUM_BP),
    .CYCLE_W (CYCLE_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .halt_req    (halt_req),
    .cmd         (bus.slave),
    .cpu_en      (cpu_en),
    .halted      (halted),
    .halt_cause  (halt_cause),
    .bp_idx      (bp_idx),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // Model: mode 0 halted, 1 running, 2 stepping.
  int          m_mode, m_rem, m_cause, m_bpi, m_cnt;
  bit          m_skip;
  logic [63:0] m_addr [NUM_BP];
  bit          m_v    [NUM_BP];

  task automatic m_reset();
    m_mode = 0; m_rem = 0; m_cause = 0; m_bpi = 0;
    m_cnt = 0; m_skip = 0;
    for (int i = 0; i < NUM_BP; i++) begin
      m_addr[i] = '0;
      m_v[i] = 0;
    end
  endtask

  function automatic int m_hit();
    for (int i = 0; i < NUM_BP; i++)
      if (m_v[i] && m_addr[i] == pc) return i;
    return -1;
  endfunction

  function automatic bit m_en();
    if (m_mode == 1) return !(!m_skip && m_hit() >= 0);
    return m_mode == 2;
  endfunction

  task automatic m_step();
    bit acc, en;
    int op, idx, h, n;
    logic [63:0] d;
    acc = bus.cmd_valid && (m_mode != 2);
    op  = int'(bus.cmd_op);
    idx = int'(bus.cmd_idx);
    d   = bus.cmd_data;
    en  = m_en();
    h   = m_hit();
    if (acc && op == 6) m_cnt = 0;
    else if (en && m_cnt < (1 << CYCLE_W) - 1) m_cnt++;
    if (acc && op == 4 && idx < NUM_BP) begin
      m_addr[idx] = d;
      m_v[idx] = 1;
    end
    if (acc && op == 5 && idx < NUM_BP) m_v[idx] = 0;
    case (m_mode)
      0: if (acc && !halt_req) begin
        if (op == 1) begin
          m_mode = 1; m_skip = 1;
        end else if (op == 3) begin
          n = int'(d[CYCLE_W-1:0]);
          m_rem = (n == 0) ? 1 : n;
          m_mode = 2;
        end
      end
      1: begin
        m_skip = 0;
        if (halt_req) begin m_mode = 0; m_cause = 4; end
        else if (!en) begin m_mode = 0; m_cause = 2; m_bpi = h; end
        else if (acc && op == 2) begin m_mode = 0; m_cause = 1; end
      end
      default: begin
        if (halt_req) begin m_mode = 0; m_cause = 4; end
        else if (m_rem == 1) begin m_mode = 0; m_cause = 3; end
        else m_rem--;
      end
    endcase
    // Simple CPU: a 32-instruction loop.
    if (en) pc <= (pc + 64'd4) & 64'h7F;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("cpu_en", 64'(cpu_en), 64'(m_en()));
      chk("halted", 64'(halted), 64'(m_mode == 0));
      chk("cmd_ready", 64'(bus.cmd_ready),
          64'(rst_n && m_mode != 2));
      chk("halt_cause", 64'(halt_cause), 64'(m_cause));
      chk("bp_idx", 64'(bp_idx), 64'(m_bpi));
      chk("cycle_count", 64'(cycle_count), 64'(m_cnt));
    end
  end

  task automatic do_cmd(input int op, input int idx,
                        input logic [63:0] data);
    bit ok;
    ok = 0;
    @(posedge clk); #2;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_idx   = IDX_W'(idx);
    bus.cmd_data  = data;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin ok = 1; break; end
    end
    if (!ok) timeout("cmd_accept");
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
  endtask

  task automatic wait_halt(input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (halted) return;
    end
    timeout("wait_halt");
  endtask

  task automatic step_run(input logic [63:0] n, output int ens,
                          output int nrdy);
    ens = 0; nrdy = 0;
    do_cmd(3, 0, n);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (halted) break;
      if (cpu_en) ens++;
      if (!bus.cmd_ready) nrdy++;
    end
    chk("step_done_halted", 64'(halted), 64'd1);
  endtask

  initial begin
    int ens, nrdy;
    #1_000_000;
    $display("FAIL watchdog: no finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ens, nrdy;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_idx   = '0;
    bus.cmd_data  = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rst_halted", 64'(halted), 64'd1);
    chk("rst_cause", 64'(halt_cause), 64'd0);
    chk("rst_bp_idx", 64'(bp_idx), 64'd0);
    chk("rst_count", 64'(cycle_count), 64'd0);
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);

    // Free run, then halt by command.
    do_cmd(1, 0, 0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("run10_count", 64'(cycle_count), 64'd10);
    chk("run10_pc", pc, 64'h28);
    do_cmd(2, 0, 0);
    @(negedge clk);
    chk("cmd_halt_cause", 64'(halt_cause), 64'd1);
    do_cmd(6, 0, 0);
    @(negedge clk);
    chk("clr_cnt", 64'(cycle_count), 64'd0);

    // Breakpoint at 0x20 then resume past it.
    pc = '0;
    do_cmd(4, 1, 64'h20);
    do_cmd(1, 0, 0);
    wait_halt(40);
    chk("bp_pc", pc, 64'h20);
    chk("bp_cause", 64'(halt_cause), 64'd2);
    chk("bp_idx1", 64'(bp_idx), 64'd1);
    chk("bp_count", 64'(cycle_count), 64'd8);
    do_cmd(1, 0, 0);
    @(negedge clk);
    chk("resume_en_at_bp", 64'(cpu_en), 64'd1);
    @(negedge clk);
    chk("resume_pc", pc, 64'h24);
    chk("resume_running", 64'(halted), 64'd0);
    do_cmd(2, 0, 0);
    do_cmd(5, 1, 0);

    // Step counts, including zero and a count truncated to zero.
    do_cmd(6, 0, 0);
    step_run(3, ens, nrdy);
    chk("step3_cycles", 64'(ens), 64'd3);
    chk("step3_notready", 64'(nrdy), 64'd3);
    chk("step3_cause", 64'(halt_cause), 64'd3);
    step_run(0, ens, nrdy);
    chk("step0_cycles", 64'(ens), 64'd1);
    step_run(16, ens, nrdy);
    chk("step16_cycles", 64'(ens), 64'd1);
    chk("step_total", 64'(cycle_count), 64'd5);

    // External halt in the second step cycle.
    do_cmd(6, 0, 0);
    do_cmd(3, 0, 5);
    @(posedge clk); #2 halt_req = 1'b1;
    @(posedge clk); #2 halt_req = 1'b0;
    @(negedge clk);
    chk("ext_halted", 64'(halted), 64'd1);
    chk("ext_cause", 64'(halt_cause), 64'd4);
    chk("ext_count", 64'(cycle_count), 64'd2);

    // Saturation and clear during run.
    do_cmd(1, 0, 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("sat_count", 64'(cycle_count), 64'd15);
    do_cmd(6, 0, 0);
    @(negedge clk);
    chk("run_clr_count", 64'(cycle_count), 64'd0);
    do_cmd(2, 0, 0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #2;
      halt_req = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 40) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'($urandom_range(0, 7));
        bus.cmd_idx   = IDX_W'($urandom_range(0, NUM_BP - 1));
        if (bus.cmd_op == 3'd3)
          bus.cmd_data = 64'($urandom_range(0, 20));
        else
          bus.cmd_data = 64'($urandom_range(0, 31) * 4);
      end else begin
        bus.cmd_valid = 1'b0;
      end
      if (m_mode == 0 && $urandom_range(0, 99) < 10)
        pc = 64'($urandom_range(0, 31) * 4);
    end
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0;
    halt_req = 1'b0;

    // Asynchronous reset while running.
    do_cmd(2, 0, 0);
    for (int i = 0; i < NUM_BP; i++) do_cmd(5, i, 0);
    do_cmd(1, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_en", 64'(cpu_en), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cpu_en", 64'(cpu_en), 64'd0);
    chk("arst_count", 64'(cycle_count), 64'd0);
    chk("arst_halted", 64'(halted), 64'd1);
    chk("arst_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("post_rst_cause", 64'(halt_cause), 64'd0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
